// File: rtl/id_exe_reg_pkg.sv
// Shared core definitions: ALU command encodings, condition codes and status bit order.
// The control-group layout used by the ID/EXE register is also defined here.
package id_exe_reg_pkg;

    // exe_cmd 0 doubles as the bubble encoding, so MOV is 0.
    localparam logic [3:0] EXE_MOV = 4'b0000;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam logic [3:0] EXE_CMP = 4'b1100;
    localparam logic [3:0] EXE_TST = 4'b1110;
    localparam logic [3:0] EXE_LDR = 4'b1010;
    localparam logic [3:0] EXE_STR = 4'b1011;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;

    // Status vector ordering {Z,C,N,V}
    localparam int STATUS_Z = 3;
    localparam int STATUS_C = 2;
    localparam int STATUS_N = 1;
    localparam int STATUS_V = 0;

    typedef struct packed {
        logic       wb_en;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       b;
        logic       s;
        logic [3:0] exe_cmd;
        logic       valid;
    } ctrl_t;

endpackage

// File: rtl/id_exe_reg_pipe_reg.sv
// Generic pipeline register: async reset, hold when en=0, synchronous clear when en=1.
module pipe_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= clr ? '0 : d;
    end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register. Control bits become a bubble on flush, hazard or a failed
// condition; data bits clear only on flush. Freeze holds everything.
module id_exe_reg
    import id_exe_reg_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              hazard,
    input  logic              cond_pass,
    input  logic              wb_en_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              b_in,
    input  logic              s_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [3:0]        status_in,
    output logic              wb_en_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              b_out,
    output logic              s_out,
    output logic [3:0]        exe_cmd_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic [3:0]        dest_out,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [3:0]        status_out,
    output logic              valid_out
);

    localparam int CTRL_W = $bits(ctrl_t);
    localparam int DAT_W  = 1 + 12 + 24 + 3*4 + 3*DATA_W + 4;

    ctrl_t             ctrl_d, ctrl_q;
    logic [DAT_W-1:0]  data_d, data_q;
    logic              en, ctrl_clr;

    assign en       = ~freeze;
    // Flush shares the control clear; in the data register it is the only clear.
    assign ctrl_clr = flush | hazard | ~cond_pass;

    assign ctrl_d = '{wb_en:    wb_en_in,
                      mem_r_en: mem_r_en_in,
                      mem_w_en: mem_w_en_in,
                      b:        b_in,
                      s:        s_in,
                      exe_cmd:  exe_cmd_in,
                      valid:    1'b1};

    assign data_d = {imm_in, shift_operand_in, signed_imm_24_in, dest_in, src1_in, src2_in,
                     pc_in, val_rn_in, val_rm_in, status_in};

    pipe_reg #(.W(CTRL_W)) u_ctrl (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (ctrl_clr),
        .d   (ctrl_d),
        .q   (ctrl_q)
    );

    pipe_reg #(.W(DAT_W)) u_data (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (flush),
        .d   (data_d),
        .q   (data_q)
    );

    assign wb_en_out    = ctrl_q.wb_en;
    assign mem_r_en_out = ctrl_q.mem_r_en;
    assign mem_w_en_out = ctrl_q.mem_w_en;
    assign b_out        = ctrl_q.b;
    assign s_out        = ctrl_q.s;
    assign exe_cmd_out  = ctrl_q.exe_cmd;
    assign valid_out    = ctrl_q.valid;

    assign {imm_out, shift_operand_out, signed_imm_24_out, dest_out, src1_out, src2_out,
            pc_out, val_rn_out, val_rm_out, status_out} = data_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg: vector table, hand-written corner sequences and
// randomized traffic against a rule-level reference model.
module tb_id_exe_reg;
    import id_exe_reg_pkg::*;

    typedef struct packed {
        logic        wb, mr, mw, b, s;
        logic [3:0]  cmd;
        logic        imm;
        logic [11:0] shift;
        logic [23:0] simm;
        logic [3:0]  dest, src1, src2;
        logic [31:0] pc, rn, rm;
        logic [3:0]  status;
    } instr_t;

    typedef struct {
        logic   fz, fl, hz, cp;
        instr_t in;
        instr_t exp;
        logic   expv;
    } vec_t;

    logic   clk = 0, rst = 1;
    logic   freeze = 0, flush = 0, hazard = 0, cond_pass = 1;
    instr_t din = '0, act, model;
    logic   valid_out, model_v;
    int     checks = 0, errors = 0;
    vec_t   vecs[8];

    always #5 clk = ~clk;

    id_exe_reg #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
        .cond_pass(cond_pass),
        .wb_en_in(din.wb), .mem_r_en_in(din.mr), .mem_w_en_in(din.mw), .b_in(din.b),
        .s_in(din.s), .exe_cmd_in(din.cmd), .imm_in(din.imm),
        .shift_operand_in(din.shift), .signed_imm_24_in(din.simm),
        .dest_in(din.dest), .src1_in(din.src1), .src2_in(din.src2),
        .pc_in(din.pc), .val_rn_in(din.rn), .val_rm_in(din.rm), .status_in(din.status),
        .wb_en_out(act.wb), .mem_r_en_out(act.mr), .mem_w_en_out(act.mw), .b_out(act.b),
        .s_out(act.s), .exe_cmd_out(act.cmd), .imm_out(act.imm),
        .shift_operand_out(act.shift), .signed_imm_24_out(act.simm),
        .dest_out(act.dest), .src1_out(act.src1), .src2_out(act.src2),
        .pc_out(act.pc), .val_rn_out(act.rn), .val_rm_out(act.rm), .status_out(act.status),
        .valid_out(valid_out)
    );

    function automatic instr_t mk(logic [3:0] cmd, logic wb, mr, mw, b, s,
                                  logic [3:0] dest, logic [31:0] rn, rm, pc);
        instr_t x;
        x = '0;
        x.cmd = cmd; x.wb = wb; x.mr = mr; x.mw = mw; x.b = b; x.s = s;
        x.dest = dest; x.rn = rn; x.rm = rm; x.pc = pc;
        x.imm = 1'b1; x.shift = 12'h0A5; x.src1 = 4'd1; x.src2 = 4'd2; x.status = 4'b0100;
        return x;
    endfunction

    // A bubble keeps the data fields but carries no side-effecting control.
    function automatic instr_t bubble(instr_t x);
        instr_t y;
        y = x;
        y.wb = 0; y.mr = 0; y.mw = 0; y.b = 0; y.s = 0; y.cmd = 4'd0;
        return y;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t x;
        x = '0;
        x.wb = 1'($urandom); x.mr = 1'($urandom); x.mw = 1'($urandom);
        x.b = 1'($urandom); x.s = 1'($urandom); x.cmd = 4'($urandom);
        x.imm = 1'($urandom); x.shift = 12'($urandom); x.simm = 24'($urandom);
        x.dest = 4'($urandom); x.src1 = 4'($urandom); x.src2 = 4'($urandom);
        x.pc = $urandom; x.rn = $urandom; x.rm = $urandom; x.status = 4'($urandom);
        return x;
    endfunction

    // Reference: what EXE should see after one edge given the priority rules.
    task automatic model_edge(logic fz, fl, hz, cp, instr_t in);
        if (fz) begin
        end else if (fl) begin
            model = '0; model_v = 0;
        end else if (hz || !cp) begin
            model = bubble(in); model_v = 0;
        end else begin
            model = in; model_v = 1;
        end
    endtask

    task automatic step(logic fz, fl, hz, cp, instr_t in);
        @(negedge clk);
        freeze = fz; flush = fl; hazard = hz; cond_pass = cp; din = in;
        model_edge(fz, fl, hz, cp, in);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, instr_t e, logic ev);
        checks++;
        if (act !== e || valid_out !== ev) begin
            errors++;
            $display("FAIL %s: got %h valid=%b, expected %h valid=%b", name, act, valid_out, e, ev);
        end
    endtask

    instr_t add_i, str_i, ldr_i, br_i, tmp;

    initial begin
        add_i = mk(EXE_ADD, 1, 0, 0, 0, 1, 4'd3, 32'd5, 32'd7, 32'h0000_0008);
        str_i = mk(EXE_STR, 0, 0, 1, 0, 0, 4'd4, 32'h100, 32'h55, 32'h0000_0010);
        ldr_i = mk(EXE_LDR, 1, 1, 0, 0, 0, 4'd6, 32'h200, 32'h0, 32'h0000_0014);
        br_i  = mk(EXE_MOV, 0, 0, 0, 1, 0, 4'd0, 32'h0, 32'h0, 32'h0000_0018);
        br_i.simm = 24'hFFFFFE;

        //              fz fl hz cp  in      expected         v
        vecs[0] = '{0, 0, 0, 1, add_i, add_i,          1};
        vecs[1] = '{0, 0, 0, 0, add_i, bubble(add_i),  0};
        vecs[2] = '{0, 0, 1, 1, str_i, bubble(str_i),  0};
        vecs[3] = '{0, 0, 0, 1, str_i, str_i,          1};
        vecs[4] = '{0, 1, 0, 1, ldr_i, '0,             0};
        vecs[5] = '{0, 1, 1, 1, ldr_i, '0,             0};
        vecs[6] = '{0, 1, 0, 0, add_i, '0,             0};
        vecs[7] = '{0, 0, 1, 0, br_i,  bubble(br_i),   0};

        model = '0; model_v = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", '0, 0);
        @(negedge clk);
        rst = 0;

        foreach (vecs[i])
            begin
                step(vecs[i].fz, vecs[i].fl, vecs[i].hz, vecs[i].cp, vecs[i].in);
                chk($sformatf("vec%0d", i), vecs[i].exp, vecs[i].expv);
            end

        // Async reset in the middle of a cycle with the register loaded.
        step(0, 0, 0, 1, add_i);
        #2 rst = 1;
        #1 chk("async_reset", '0, 0);
        @(negedge clk);
        rst = 0;
        tmp = add_i; tmp.pc = 32'h0000_0004;
        step(0, 0, 0, 1, tmp);
        chk("reset_release_load", tmp, 1);

        // Freeze overrides flush, then flush clears once freeze drops.
        step(0, 0, 0, 1, ldr_i);
        step(1, 1, 0, 1, str_i);
        chk("freeze_flush_hold", ldr_i, 1);
        step(0, 1, 0, 1, str_i);
        chk("flush_after_freeze", '0, 0);

        // Branch held across three frozen cycles of changing inputs.
        step(0, 0, 0, 1, br_i);
        chk("branch_load", br_i, 1);
        for (int k = 0; k < 3; k++) begin
            step(1, 0, k[0], 1, rnd_instr());
            chk($sformatf("freeze_hold%0d", k), br_i, 1);
        end
        step(0, 0, 0, 1, add_i);
        chk("unfreeze_load", add_i, 1);

        // Randomized traffic with biased control inputs.
        for (int n = 0; n < 400; n++) begin
            step(($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 5) == 0,
                 ($urandom % 4) != 0, rnd_instr());
            chk("random", model, model_v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
